native_bank_dispatch: RTL and testbench
=======================================

// Module: native_bank_dispatch
// PURPOSE
//  Single-master dispatcher between the user native port (cmd/wdata/rdata) and the 8 per-bank
//  litedram command interfaces plus the shared litedram data interface. Decodes bank from the native
//  address, steers commands to the owning bank machine, buffers write data ahead of bank wdata_ready,
//  and buffers read data so native rdata_ready backpressure never loses a beat (credit-limited reads).
// PARAMETERS
//  AW           26   native address width
//  BAW          23   bank-interface address width (AW-3)
//  DW           256  data width
//  COL_BITS     7    native addr bits below the bank field
//  WDATA_DEPTH  4    write-data FIFO entries (power of 2)
//  RDATA_DEPTH  8    read-data FIFO entries (power of 2) = max in-flight+buffered reads
// PORTS
//  clk                    in   1        clock
//  rst                    in   1        reset, synchronous, active-low
//  native_cmd_valid       in   1        command valid
//  native_cmd_ready       out  1        command accepted this cycle (valid&ready)
//  native_cmd_payload_we  in   1        1=write 0=read
//  native_cmd_payload_mw  in   1        masked write, passed to bank
//  native_cmd_payload_addr in  AW       word address
//  wdata_valid/_ready     in/out 1      write-data handshake
//  wdata_payload_data     in   DW       write data
//  wdata_payload_we       in   DW/8     byte enables
//  rdata_valid/_ready     out/in 1      read-data handshake
//  rdata_first/_last      out  1        both = rdata_valid (single-beat)
//  rdata_payload_data     out  DW       read data
//  bank_valid             out  8        per-bank interface_bank_valid
//  bank_ready             in   8        per-bank interface_bank_ready
//  bank_we / bank_mw      out  1        broadcast to all banks
//  bank_addr              out  BAW      broadcast bank address
//  bank_wdata_ready       in   8        per-bank wdata request
//  bank_rdata_valid       in   8        per-bank read return
//  interface_wdata        out  DW       write-FIFO head data
//  interface_wdata_we     out  DW/8     write-FIFO head enables; 0 when FIFO empty
//  interface_rdata        in   DW       shared read data
// BEHAVIOUR
//  - bank = addr[COL_BITS+:3]; bank_addr = {addr[AW-1:COL_BITS+3], addr[COL_BITS-1:0]}; combinational.
//  - ok_wr = we & (wr_pend < wcount); ok_rd = ~we & (rd_out + rcount < RDATA_DEPTH).
//  - bank_valid[b] = cmd_valid & (bank==b) & (ok_wr|ok_rd); native_cmd_ready = bank_ready[bank] & (ok_wr|ok_rd).
//  - Write FIFO: push on wdata_valid&wdata_ready; wdata_ready = ~full | pop (pop-through when full).
//    Pop when |bank_wdata_ready; wr_pend (pending write cmds) +1 on write accept, -1 on pop, same-cycle net 0.
//  - Read path: rd_out +1 on read accept, -1 on |bank_rdata_valid; interface_rdata pushed into read FIFO
//    same cycle; rdata_valid = ~rempty, data = head (registered FIFO, 1-cycle latency from bank_rdata_valid).
//    Simultaneous push/pop on full rd FIFO legal; counts unchanged.
//  - Credit rule guarantees read FIFO never overflows and bank wdata_ready never sees empty FIFO
//    under legal bank behaviour.
//  - More than one bit of bank_wdata_ready or bank_rdata_valid set in one cycle: protocol violation;
//    treat as one event.
//  - Reset (rst=0 at clk edge): FIFOs empty, wr_pend=rd_out=0; native_cmd_ready=0, wdata_ready=0 during
//    reset, bank_valid=0, rdata_valid=0, interface_wdata_we=0, err=0. Mid-operation reset drops all
//    in-flight state; late bank returns after reset are dropped (rd_out saturates at 0).
//  - Counters sized $clog2(DEPTH)+1; no wrap.
// CONFIGURATION
//  NATIVE_DISPATCH_CHECK_EN defined: adds output err (1 bit), sticky until reset; set on
//    bank_wdata_ready with empty write FIFO, bank_rdata_valid with rd_out==0, or >1 bank bit set.
//    Illegal bank_wdata_ready pops nothing; illegal bank_rdata_valid with rd_out==0 is dropped.
//  Undefined: no err port, no checker logic; behaviour otherwise identical.
// TESTING
//  1 rst=0 3 cycles -> bank_valid=0, rdata_valid=0, native_cmd_ready=0, interface_wdata_we=0.
//  2 wdata beat D0 first, then write addr 26'h0001F85, bank_ready=8'hFF -> bank_valid=8'h80,
//    bank_addr=23'h385, bank_we=1; bank_wdata_ready[7] -> interface_wdata=D0, FIFO empty after.
//  3 write cmd with write FIFO empty -> native_cmd_ready=0; wdata beat accepted -> ready=1 next cycle.
//  4 8 reads, rdata_ready=0, banks return all 8 -> 9th read held (ready=0); 1 rdata pop -> 9th accepted.
//  5 write FIFO full, wdata_valid=1 with bank_wdata_ready=1 same cycle -> wdata_ready=1, count stays 4.
//  6 NATIVE_DISPATCH_CHECK_EN: bank_wdata_ready[2]=1 with FIFO empty -> err=1, held until rst=0.

Source files
------------

// File: rtl/native_bank_dispatch_if.sv
// rtl/native_bank_dispatch_if.sv - native port and per-bank litedram signal bundle
// slave modport is the dispatcher side, master modport is the native user / bank environment side.
interface native_bank_dispatch_if #(
  parameter int AW  = 26,
  parameter int BAW = 23,
  parameter int DW  = 256
);
  logic              native_cmd_valid;
  logic              native_cmd_ready;
  logic              native_cmd_payload_we;
  logic              native_cmd_payload_mw;
  logic [AW-1:0]     native_cmd_payload_addr;
  logic              wdata_valid;
  logic              wdata_ready;
  logic [DW-1:0]     wdata_payload_data;
  logic [DW/8-1:0]   wdata_payload_we;
  logic              rdata_valid;
  logic              rdata_ready;
  logic              rdata_first;
  logic              rdata_last;
  logic [DW-1:0]     rdata_payload_data;
  logic [7:0]        bank_valid;
  logic [7:0]        bank_ready;
  logic              bank_we;
  logic              bank_mw;
  logic [BAW-1:0]    bank_addr;
  logic [7:0]        bank_wdata_ready;
  logic [7:0]        bank_rdata_valid;
  logic [DW-1:0]     interface_wdata;
  logic [DW/8-1:0]   interface_wdata_we;
  logic [DW-1:0]     interface_rdata;

  modport slave (
    input  native_cmd_valid, native_cmd_payload_we, native_cmd_payload_mw, native_cmd_payload_addr,
    output native_cmd_ready,
    input  wdata_valid, wdata_payload_data, wdata_payload_we,
    output wdata_ready,
    output rdata_valid, rdata_first, rdata_last, rdata_payload_data,
    input  rdata_ready,
    output bank_valid, bank_we, bank_mw, bank_addr, interface_wdata, interface_wdata_we,
    input  bank_ready, bank_wdata_ready, bank_rdata_valid, interface_rdata
  );

  modport master (
    output native_cmd_valid, native_cmd_payload_we, native_cmd_payload_mw, native_cmd_payload_addr,
    input  native_cmd_ready,
    output wdata_valid, wdata_payload_data, wdata_payload_we,
    input  wdata_ready,
    input  rdata_valid, rdata_first, rdata_last, rdata_payload_data,
    output rdata_ready,
    input  bank_valid, bank_we, bank_mw, bank_addr, interface_wdata, interface_wdata_we,
    output bank_ready, bank_wdata_ready, bank_rdata_valid, interface_rdata
  );
endinterface

// File: rtl/native_bank_dispatch.sv
// rtl/native_bank_dispatch.sv - native port to 8 litedram bank machines, credit-limited read buffering
// Optional protocol checker with sticky err output: define NATIVE_DISPATCH_CHECK_EN.
module native_bank_dispatch #(
  parameter int AW          = 26,
  parameter int BAW         = 23,
  parameter int DW          = 256,
  parameter int COL_BITS    = 7,
  parameter int WDATA_DEPTH = 4,
  parameter int RDATA_DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
`ifdef NATIVE_DISPATCH_CHECK_EN
  output logic                   err,
`endif
  native_bank_dispatch_if.slave  io
);
  localparam int WAW = $clog2(WDATA_DEPTH);
  localparam int WCW = WAW + 1;
  localparam int RAW = $clog2(RDATA_DEPTH);
  localparam int RCW = RAW + 1;

  logic [2:0]     bank;
  logic           ok_wr, ok_rd, cmd_ok, wr_acc, rd_acc;
  logic [WCW-1:0] wcount, wr_pend;
  logic [RCW-1:0] rcount, rd_out;
  logic [WAW-1:0] wwr_ptr, wrd_ptr;
  logic [RAW-1:0] rwr_ptr, rrd_ptr;
  logic           wempty, wfull, wpush, wpop;
  logic           rempty, rpush, rpop;

  logic [DW-1:0]   wmem_data [WDATA_DEPTH];
  logic [DW/8-1:0] wmem_be   [WDATA_DEPTH];
  logic [DW-1:0]   rmem_data [RDATA_DEPTH];

  assign bank         = io.native_cmd_payload_addr[COL_BITS +: 3];
  assign io.bank_addr = {io.native_cmd_payload_addr[AW-1:COL_BITS+3],
                         io.native_cmd_payload_addr[COL_BITS-1:0]};
  assign io.bank_we   = io.native_cmd_payload_we;
  assign io.bank_mw   = io.native_cmd_payload_mw;

  // Writes need their data already buffered; reads need a free read-FIFO slot reserved.
  assign ok_wr  = io.native_cmd_payload_we && (wr_pend < wcount);
  assign ok_rd  = !io.native_cmd_payload_we &&
                  (({1'b0, rd_out} + {1'b0, rcount}) < (RCW+1)'(RDATA_DEPTH));
  assign cmd_ok = ok_wr || ok_rd;

  assign io.native_cmd_ready = rst && io.bank_ready[bank] && cmd_ok;
  assign io.bank_valid       = (rst && io.native_cmd_valid && cmd_ok) ? (8'b1 << bank) : 8'b0;
  assign wr_acc = io.native_cmd_valid && io.native_cmd_ready && io.native_cmd_payload_we;
  assign rd_acc = io.native_cmd_valid && io.native_cmd_ready && !io.native_cmd_payload_we;

  assign wempty         = (wcount == '0);
  assign wfull          = (wcount == WCW'(WDATA_DEPTH));
  assign wpop           = (|io.bank_wdata_ready) && !wempty;
  assign io.wdata_ready = rst && (!wfull || wpop);
  assign wpush          = io.wdata_valid && io.wdata_ready;

  assign io.interface_wdata    = wmem_data[wrd_ptr];
  assign io.interface_wdata_we = wempty ? '0 : wmem_be[wrd_ptr];

  // A return with no outstanding read (e.g. after reset) has no reserved slot and is dropped.
  assign rempty                = (rcount == '0);
  assign rpush                 = (|io.bank_rdata_valid) && (rd_out != '0);
  assign rpop                  = !rempty && io.rdata_ready;
  assign io.rdata_valid        = !rempty;
  assign io.rdata_first        = !rempty;
  assign io.rdata_last         = !rempty;
  assign io.rdata_payload_data = rmem_data[rrd_ptr];

  always_ff @(posedge clk) begin
    if (wpush) begin
      wmem_data[wwr_ptr] <= io.wdata_payload_data;
      wmem_be[wwr_ptr]   <= io.wdata_payload_we;
    end
    if (rpush) rmem_data[rwr_ptr] <= io.interface_rdata;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wcount  <= '0;
      wr_pend <= '0;
      wwr_ptr <= '0;
      wrd_ptr <= '0;
      rcount  <= '0;
      rd_out  <= '0;
      rwr_ptr <= '0;
      rrd_ptr <= '0;
    end else begin
      if (wpush) wwr_ptr <= wwr_ptr + 1'b1;
      if (wpop)  wrd_ptr <= wrd_ptr + 1'b1;
      if (wpush && !wpop)      wcount <= wcount + 1'b1;
      else if (!wpush && wpop) wcount <= wcount - 1'b1;

      if (wr_acc && !wpop)                         wr_pend <= wr_pend + 1'b1;
      else if (!wr_acc && wpop && wr_pend != '0)   wr_pend <= wr_pend - 1'b1;

      if (rpush) rwr_ptr <= rwr_ptr + 1'b1;
      if (rpop)  rrd_ptr <= rrd_ptr + 1'b1;
      if (rpush && !rpop)      rcount <= rcount + 1'b1;
      else if (!rpush && rpop) rcount <= rcount - 1'b1;

      if (rd_acc && !rpush)      rd_out <= rd_out + 1'b1;
      else if (!rd_acc && rpush) rd_out <= rd_out - 1'b1;
    end
  end

`ifdef NATIVE_DISPATCH_CHECK_EN
  logic multi_w, multi_r, bad_w, bad_r;
  assign multi_w = |(io.bank_wdata_ready & (io.bank_wdata_ready - 8'd1));
  assign multi_r = |(io.bank_rdata_valid & (io.bank_rdata_valid - 8'd1));
  assign bad_w   = (|io.bank_wdata_ready) && wempty;
  assign bad_r   = (|io.bank_rdata_valid) && (rd_out == '0);

  always_ff @(posedge clk) begin
    if (!rst) err <= 1'b0;
    else if (multi_w || multi_r || bad_w || bad_r) err <= 1'b1;
  end
`endif
endmodule

// File: tb/tb_native_bank_dispatch.sv
// tb/tb_native_bank_dispatch.sv - directed self-checking bench for native_bank_dispatch
// Define NATIVE_DISPATCH_CHECK_EN to also exercise the err checker.
module tb_native_bank_dispatch;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
`ifdef NATIVE_DISPATCH_CHECK_EN
  logic err;
`endif

  native_bank_dispatch_if #(.AW(26), .BAW(23), .DW(256)) io ();

  native_bank_dispatch dut (
    .clk (clk),
    .rst (rst),
`ifdef NATIVE_DISPATCH_CHECK_EN
    .err (err),
`endif
    .io  (io)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  logic [255:0] d0, d1;
  logic [255:0] rexp [$];

  initial begin
    d0 = {8{32'hD0D0_0001}};
    d1 = {8{32'hD1D1_0002}};
    rst = 1'b0;
    io.native_cmd_valid = 1'b1;
    io.native_cmd_payload_we = 1'b0;
    io.native_cmd_payload_mw = 1'b0;
    io.native_cmd_payload_addr = '0;
    io.wdata_valid = 1'b0;
    io.wdata_payload_data = '0;
    io.wdata_payload_we = '1;
    io.rdata_ready = 1'b0;
    io.bank_ready = 8'hFF;
    io.bank_wdata_ready = 8'h00;
    io.bank_rdata_valid = 8'h00;
    io.interface_rdata = '0;

    // reset state
    repeat (3) step();
    check("rst_bank_valid", io.bank_valid, 8'h00);
    check("rst_rdata_valid", io.rdata_valid, 1'b0);
    check("rst_cmd_ready", io.native_cmd_ready, 1'b0);
    check("rst_wdata_we", io.interface_wdata_we, 32'h0);
    check("rst_wdata_ready", io.wdata_ready, 1'b0);
    rst = 1'b1;
    io.native_cmd_valid = 1'b0;

    // write data ahead of the command, then decode to bank 7
    io.wdata_valid = 1'b1;
    io.wdata_payload_data = d0;
    #1 check("wr_wdata_ready", io.wdata_ready, 1'b1);
    step();
    io.wdata_valid = 1'b0;
    io.native_cmd_valid = 1'b1;
    io.native_cmd_payload_we = 1'b1;
    io.native_cmd_payload_addr = 26'h0001F85;
    #1;
    check("wr_bank_valid", io.bank_valid, 8'h80);
    check("wr_bank_addr", io.bank_addr, 23'h385);
    check("wr_bank_we", io.bank_we, 1'b1);
    check("wr_cmd_ready", io.native_cmd_ready, 1'b1);
    step();
    io.native_cmd_valid = 1'b0;
    io.bank_wdata_ready = 8'h80;
    #1;
    check("wr_if_wdata", io.interface_wdata, d0);
    check("wr_if_we", io.interface_wdata_we, 32'hFFFF_FFFF);
    step();
    io.bank_wdata_ready = 8'h00;
    #1 check("wr_fifo_empty", io.interface_wdata_we, 32'h0);

    // write command waits for its data
    io.native_cmd_valid = 1'b1;
    io.native_cmd_payload_addr = 26'h0;
    #1;
    check("nodata_cmd_ready", io.native_cmd_ready, 1'b0);
    check("nodata_bank_valid", io.bank_valid, 8'h00);
    io.wdata_valid = 1'b1;
    io.wdata_payload_data = d1;
    step();
    io.wdata_valid = 1'b0;
    #1 check("data_cmd_ready", io.native_cmd_ready, 1'b1);
    step();
    io.native_cmd_valid = 1'b0;
    io.bank_wdata_ready = 8'h01;
    #1 check("nodata_if_wdata", io.interface_wdata, d1);
    step();
    io.bank_wdata_ready = 8'h00;

    // read credits: 8 in flight, returns fill the FIFO, 9th held until a pop
    io.native_cmd_valid = 1'b1;
    io.native_cmd_payload_we = 1'b0;
    for (int i = 0; i < 8; i++) begin
      io.native_cmd_payload_addr = 26'(i << 7);
      #1 check("rd_credit_ready", io.native_cmd_ready, 1'b1);
      step();
    end
    io.native_cmd_payload_addr = 26'h0;
    #1 check("rd_out_full_ready", io.native_cmd_ready, 1'b0);
    for (int i = 0; i < 8; i++) begin
      io.bank_rdata_valid = 8'(1 << i);
      io.interface_rdata = 256'(1000 + i);
      rexp.push_back(256'(1000 + i));
      step();
    end
    io.bank_rdata_valid = 8'h00;
    #1;
    check("rd_valid", io.rdata_valid, 1'b1);
    check("rd_first_last", {io.rdata_first, io.rdata_last}, 2'b11);
    check("rd_head", io.rdata_payload_data, rexp[0]);
    check("rd_9th_held", io.native_cmd_ready, 1'b0);
    io.rdata_ready = 1'b1;
    step();
    void'(rexp.pop_front());
    io.rdata_ready = 1'b0;
    #1;
    check("rd_9th_ready", io.native_cmd_ready, 1'b1);
    check("rd_head2", io.rdata_payload_data, rexp[0]);
    step();
    io.native_cmd_valid = 1'b0;
    io.bank_rdata_valid = 8'h01;
    io.interface_rdata = 256'(2000);
    rexp.push_back(256'(2000));
    step();
    io.bank_rdata_valid = 8'h00;
    io.rdata_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      check("rd_drain_valid", io.rdata_valid, 1'b1);
      check("rd_drain_data", io.rdata_payload_data, rexp.pop_front());
      step();
    end
    io.rdata_ready = 1'b0;
    #1 check("rd_drained", io.rdata_valid, 1'b0);

    // write FIFO full with pop-through
    io.wdata_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      io.wdata_payload_data = 256'(32'hA000 + i);
      step();
    end
    io.wdata_payload_data = 256'(32'hA004);
    #1 check("wfull_ready", io.wdata_ready, 1'b0);
    io.bank_wdata_ready = 8'h01;
    #1;
    check("wfull_popthru_ready", io.wdata_ready, 1'b1);
    check("wfull_head", io.interface_wdata, 256'(32'hA000));
    step();
    io.wdata_valid = 1'b0;
    io.bank_wdata_ready = 8'h00;
    #1;
    check("wfull_still_full", io.wdata_ready, 1'b0);
    io.bank_wdata_ready = 8'h01;
    for (int i = 1; i < 5; i++) begin
      #1 check("wfull_drain", io.interface_wdata, 256'(32'hA000 + i));
      step();
    end
    io.bank_wdata_ready = 8'h00;
    #1 check("wfull_drained", io.interface_wdata_we, 32'h0);

`ifdef NATIVE_DISPATCH_CHECK_EN
    check("err_clean", err, 1'b0);
    io.bank_wdata_ready = 8'h04;
    step();
    io.bank_wdata_ready = 8'h00;
    #1 check("err_set", err, 1'b1);
    repeat (3) step();
    check("err_sticky", err, 1'b1);
    rst = 1'b0;
    step();
    rst = 1'b1;
    #1 check("err_cleared", err, 1'b0);
`endif

    // mid-flight reset drops the outstanding read and its late return
    io.native_cmd_valid = 1'b1;
    io.native_cmd_payload_we = 1'b0;
    io.native_cmd_payload_addr = 26'h0;
    step();
    io.native_cmd_valid = 1'b0;
    rst = 1'b0;
    step();
    rst = 1'b1;
    io.bank_rdata_valid = 8'h01;
    io.interface_rdata = 256'(3000);
    step();
    io.bank_rdata_valid = 8'h00;
    #1 check("late_return_dropped", io.rdata_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
